contador_programa_pilha: RTL and testbench

CONTADOR_PROGRAMA_PILHA -- requirements
Module: contador_programa_pilha

---
 rtl/contador_programa_pilha.sv | 112 +++++++++++
 tb/tb_contador_programa_pilha.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/contador_programa_pilha.sv
// contador_programa_pilha
// Program counter with sequential increment, branch, and a small return stack
// for subroutine call/return.
//
// Request handshake: there is no valid/ready pair. Each request input is
// sampled only on a rising edge of clock where habilita=1. Priority among
// simultaneous requests is retorno > chamada > desvio > increment.
// - A call on a full stack still jumps, drops the push and raises the
//   sticky erro flag.
// - A return on an empty stack increments instead and raises erro.
module contador_programa_pilha #(
    parameter int                   LARGURA      = 64,
    parameter logic [LARGURA-1:0]   INCREMENTO   = LARGURA'(1),
    parameter logic [LARGURA-1:0]   VETOR_RESET  = '0,
    parameter int                   PROFUNDIDADE = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               habilita,
    input  logic               desvio,
    input  logic               chamada,
    input  logic               retorno,
    input  logic [LARGURA-1:0] alvo,
    output logic [LARGURA-1:0] endereco,
    output logic               pilha_vazia,
    output logic               pilha_cheia,
    output logic               erro
);

    // Stack index width and occupancy width (occupancy spans 0..PROFUNDIDADE).
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int OW = PW + 1;

    logic [LARGURA-1:0] r_pc;
    logic [OW-1:0]      r_ocup;
    logic               r_erro;
    logic [LARGURA-1:0] r_pilha [PROFUNDIDADE];

    logic [LARGURA-1:0] w_pc_inc;
    logic [PW-1:0]      w_idx_push;
    logic [PW-1:0]      w_idx_topo;
    logic               w_vazia;
    logic               w_cheia;
    logic               w_ret_ok;
    logic               w_ret_erro;
    logic               w_cham_ok;
    logic               w_cham_erro;
    logic [LARGURA-1:0] w_pc_prox;
    logic [OW-1:0]      w_ocup_prox;
    logic               w_erro_prox;

    // Shared helpers: next sequential address, stack pointers and
    // full/empty flags decoded from the registered occupancy.
    assign w_pc_inc   = r_pc + INCREMENTO;
    assign w_idx_push = r_ocup[PW-1:0];
    assign w_idx_topo = w_idx_push - PW'(1);
    assign w_vazia    = (r_ocup == '0);
    assign w_cheia    = (r_ocup == OW'(PROFUNDIDADE));

    // Classify this cycle's request. A return always masks a call.
    assign w_ret_ok    = retorno && !w_vazia;
    assign w_ret_erro  = retorno &&  w_vazia;
    assign w_cham_ok   = chamada && !retorno && !w_cheia;
    assign w_cham_erro = chamada && !retorno &&  w_cheia;

    // Next-state selection for PC, occupancy and error flag.
    always_comb begin
        w_pc_prox   = w_pc_inc;
        w_ocup_prox = r_ocup;
        w_erro_prox = r_erro | w_ret_erro | w_cham_erro;
        if (retorno) begin
            if (w_ret_ok) begin
                w_pc_prox   = r_pilha[w_idx_topo];
                w_ocup_prox = r_ocup - OW'(1);
            end
        end else if (chamada) begin
            w_pc_prox = alvo;
            if (w_cham_ok) begin
                w_ocup_prox = r_ocup + OW'(1);
            end
        end else if (desvio) begin
            w_pc_prox = alvo;
        end
    end

    // Architectural state: PC, occupancy and sticky error; reset is async.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc   <= VETOR_RESET;
            r_ocup <= '0;
            r_erro <= 1'b0;
        end else if (habilita) begin
            r_pc   <= w_pc_prox;
            r_ocup <= w_ocup_prox;
            r_erro <= w_erro_prox;
        end
    end

    // Stack storage is not cleared; an entry is visible only once occupancy
    // covers it. Reset blocks a push in the same cycle.
    always_ff @(posedge clock) begin
        if (reset_n && habilita && w_cham_ok) begin
            r_pilha[w_idx_push] <= w_pc_inc;
        end
    end

    assign endereco    = r_pc;
    assign pilha_vazia = w_vazia;
    assign pilha_cheia = w_cheia;
    assign erro        = r_erro;

endmodule

// File: tb/tb_contador_programa_pilha.sv
// Bench for contador_programa_pilha with LARGURA=16, INCREMENTO=4,
// VETOR_RESET=0100, PROFUNDIDADE=4. A queue-based model predicts every
// output; directed sequences add literal expectations at key points.
module tb_contador_programa_pilha;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         habilita, desvio, chamada, retorno;
  logic [W-1:0] alvo;
  logic [W-1:0] endereco;
  logic         pilha_vazia, pilha_cheia, erro;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  bit           m_erro;

  contador_programa_pilha #(
    .LARGURA(16), .INCREMENTO(16'd4), .VETOR_RESET(16'h0100), .PROFUNDIDADE(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .desvio(desvio),
    .chamada(chamada), .retorno(retorno), .alvo(alvo), .endereco(endereco),
    .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia), .erro(erro)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 16'h0100;
    m_stack.delete();
    m_erro = 1'b0;
  endfunction

  function automatic void model_step(input bit h, input bit d, input bit c, input bit r,
                                     input logic [W-1:0] a);
    logic [W-1:0] seq;
    if (!h) return;
    seq = m_pc + 16'd4;
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = seq; m_erro = 1'b1; end
    end else if (c) begin
      if (m_stack.size() < 4) m_stack.push_back(seq);
      else m_erro = 1'b1;
      m_pc = a;
    end else if (d) begin
      m_pc = a;
    end else begin
      m_pc = seq;
    end
  endfunction

  // scoreboard compare: every cycle, outputs vs model
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      chk("model_pc",    endereco, m_pc);
      chk("model_vazia", {15'd0, pilha_vazia}, {15'd0, m_stack.size() == 0});
      chk("model_cheia", {15'd0, pilha_cheia}, {15'd0, m_stack.size() == 4});
      chk("model_erro",  {15'd0, erro}, {15'd0, m_erro});
    end
  end

  // driver: one clock edge with the given inputs
  task automatic step(input bit h, input bit d, input bit c, input bit r, input logic [W-1:0] a);
    @(negedge clock);
    habilita = h; desvio = d; chamada = c; retorno = r; alvo = a;
    @(posedge clock);
    if (reset_n) model_step(h, d, c, r, a);
    else model_reset();
    #2;
  endtask

  task automatic idle();              step(1, 0, 0, 0, 16'h0000); endtask
  task automatic jump(input logic [W-1:0] a); step(1, 1, 0, 0, a); endtask
  task automatic call(input logic [W-1:0] a); step(1, 0, 1, 0, a); endtask
  task automatic ret();               step(1, 0, 0, 1, 16'h0000); endtask

  task automatic lit(input string name, input logic [W-1:0] pc, input bit v, input bit c, input bit e);
    chk({name, "_pc"}, endereco, pc);
    chk({name, "_vazia"}, {15'd0, pilha_vazia}, {15'd0, v});
    chk({name, "_cheia"}, {15'd0, pilha_cheia}, {15'd0, c});
    chk({name, "_erro"}, {15'd0, erro}, {15'd0, e});
    chk({name, "_model"}, m_pc, pc);
  endtask

  initial begin
    reset_n = 1'b0; habilita = 0; desvio = 0; chamada = 0; retorno = 0; alvo = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    lit("reset", 16'h0100, 1, 0, 0);
    chk_en = 1'b1;
    @(negedge clock); reset_n = 1'b1;

    // three sequential edges
    idle(); lit("seq1", 16'h0104, 1, 0, 0);
    idle(); lit("seq2", 16'h0108, 1, 0, 0);
    idle(); lit("seq3", 16'h010C, 1, 0, 0);

    // branch back to 0108, then call / return
    jump(16'h0108); lit("desvio", 16'h0108, 1, 0, 0);
    call(16'h0200); lit("call", 16'h0200, 0, 0, 0);
    idle();         lit("sub1", 16'h0204, 0, 0, 0);
    idle();         lit("sub2", 16'h0208, 0, 0, 0);
    ret();          lit("ret",  16'h010C, 1, 0, 0);

    // nested calls up to full, then overflow
    call(16'h1000); call(16'h2000); call(16'h3000);
    lit("nest3", 16'h3000, 0, 0, 0);
    call(16'h4000); lit("nest4", 16'h4000, 0, 1, 0);
    call(16'h5000); lit("ovf",   16'h5000, 0, 1, 1);
    ret(); lit("pop1", 16'h3004, 0, 0, 1);
    ret(); lit("pop2", 16'h2004, 0, 0, 1);
    ret(); lit("pop3", 16'h1004, 0, 0, 1);
    ret(); lit("pop4", 16'h0110, 1, 0, 1);
    ret(); lit("udf",  16'h0114, 1, 0, 1);

    // wrap-around of the increment and of the pushed return address
    jump(16'hFFFC); idle(); lit("wrap", 16'h0000, 1, 0, 1);
    jump(16'hFFFC); call(16'h0300); lit("wcall", 16'h0300, 0, 0, 1);
    ret(); lit("wret", 16'h0000, 1, 0, 1);

    // all three requests together with one entry (0500)
    jump(16'h04FC); call(16'h0600); lit("one", 16'h0600, 0, 0, 1);
    step(1, 1, 1, 1, 16'h0700); lit("prio", 16'h0500, 1, 0, 1);

    // stall with a pending call
    call(16'h0800); lit("pre_stall", 16'h0800, 0, 0, 1);
    repeat (3) step(0, 1, 1, 0, 16'h0900);
    lit("stall", 16'h0800, 0, 0, 1);

    // asynchronous reset pulse between edges
    @(negedge clock); #1;
    reset_n = 1'b0; model_reset();
    #1;
    lit("async", 16'h0100, 1, 0, 0);
    #1 reset_n = 1'b1;
    idle(); lit("post_rst", 16'h0104, 1, 0, 0);

    // reset held across an edge with a call request: call is overridden
    @(negedge clock); reset_n = 1'b0; model_reset();
    call(16'h0A00); lit("rst_call", 16'h0100, 1, 0, 0);
    reset_n = 1'b1; habilita = 1'b0; chamada = 1'b0;
    step(0, 0, 0, 0, 16'h0000); lit("hold", 16'h0100, 1, 0, 0);
    idle(); lit("first", 16'h0104, 1, 0, 0);

    chk_en = 1'b0;
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
